// File: rtl/uart_tx_engine.sv
// UART transmitter with an integrated TX FIFO, runtime parity, line break
// generation and overflow flagging; queued words go out as back-to-back frames.
module uart_tx_engine #(
  parameter int SYSCLK_RATE = 1000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_WIDTH  = 4
) (
  input  logic                 SysClk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] WrData,
  input  logic                 WrEn,
  input  logic [1:0]           ParityMode,
  input  logic                 SendBreak,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Empty,
  output logic                 Full,
  output logic [FIFO_WIDTH:0]  Count,
  output logic                 Overflow
);

  localparam int DIVISOR = SYSCLK_RATE / BAUD_RATE;
  localparam int MINBRK  = (DATA_BITS + 4) * DIVISOR;
  localparam int DEPTH   = 2 ** FIFO_WIDTH;
  localparam int CW      = FIFO_WIDTH + 1;
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BRK_W   = $clog2(MINBRK + 1);
  localparam int BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [BRK_W-1:0] BRK_LAST  = BRK_W'(MINBRK - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic [CW-1:0]    DEPTH_V   = CW'(DEPTH);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx_engine: DIVISOR %0d must be at least 2", DIVISOR);
  end
  if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_engine: DATA_BITS %0d outside 1..8", DATA_BITS);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_engine: STOP_BITS %0d outside 1..2", STOP_BITS);
  end
  if (FIFO_WIDTH < 1 || FIFO_WIDTH > 16) begin : g_bad_fifo_width
    $error("uart_tx_engine: FIFO_WIDTH %0d outside 1..16", FIFO_WIDTH);
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BRK_W-1:0]     brk_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     next_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_data;
  logic                 par_en;
  logic                 par_bit;

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr;
  logic [FIFO_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_next;
  logic [DATA_BITS-1:0]  head;
  logic                  head_par_en;
  logic                  head_par_bit;
  logic                  wr_ok;
  logic                  pop;
  logic                  bit_end;
  logic                  stop_done;

  assign wr_ok        = WrEn && !Full;
  assign head         = mem[rd_ptr];
  assign head_par_en  = (ParityMode == 2'b01) || (ParityMode == 2'b10);
  assign head_par_bit = (ParityMode == 2'b01) ? ^head : ~^head;
  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign next_idx     = bit_idx + 1'b1;
  assign stop_done    = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  // A pop happens only where the FSM starts a new frame; SendBreak always wins.
  assign pop          = !Empty && !SendBreak && ((state == IDLE) || stop_done);

  always_comb begin
    count_next = Count;
    if (wr_ok && !pop) begin
      count_next = Count + 1'b1;
    end else if (pop && !wr_ok) begin
      count_next = Count - 1'b1;
    end
  end

  always_ff @(posedge SysClk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= WrData;
    end
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      Overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      Count    <= count_next;
      Full     <= (count_next == DEPTH_V);
      Empty    <= (count_next == '0);
      Overflow <= WrEn && Full;
    end
  end

  // Every transition happens on a bit boundary, so the baud counter wraps to 0 on state entry.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      brk_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_data <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      Tx         <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          brk_cnt  <= '0;
          if (SendBreak) begin
            state <= BREAK;
            Tx    <= 1'b0;
            Busy  <= 1'b1;
          end else if (!Empty) begin
            state      <= START;
            Tx         <= 1'b0;
            Busy       <= 1'b1;
            shift_data <= head;
            par_en     <= head_par_en;
            par_bit    <= head_par_bit;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            Tx      <= shift_data[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              if (par_en) begin
                state <= PARITY;
                Tx    <= par_bit;
              end else begin
                state    <= STOP;
                stop_idx <= 1'b0;
                Tx       <= 1'b1;
              end
            end else begin
              bit_idx <= next_idx;
              Tx      <= shift_data[next_idx];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
            Tx       <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              if (SendBreak) begin
                state   <= BREAK;
                brk_cnt <= '0;
                Tx      <= 1'b0;
              end else if (!Empty) begin
                state      <= START;
                Tx         <= 1'b0;
                shift_data <= head;
                par_en     <= head_par_en;
                par_bit    <= head_par_bit;
              end else begin
                state <= IDLE;
                Tx    <= 1'b1;
                Busy  <= 1'b0;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        BREAK: begin
          // brk_cnt saturates once the minimum break time has been served.
          if (brk_cnt != BRK_LAST) begin
            brk_cnt <= brk_cnt + 1'b1;
          end else if (!SendBreak) begin
            state <= IDLE;
            Tx    <= 1'b1;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames/breaks,
// a line monitor decodes Tx cycle by cycle and compares against them.
module tb_uart_tx_engine;

  localparam int DIV    = 1000000 / 9600;
  localparam int DB     = 8;
  localparam int SB     = 2;
  localparam int MINBRK = (DB + 4) * DIV;
  localparam int FRAME  = (1 + DB + SB) * DIV;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] WrData;
  logic       WrEn;
  logic [1:0] ParityMode;
  logic       SendBreak;
  logic       Tx;
  logic       Busy;
  logic       Empty;
  logic       Full;
  logic [4:0] Count;
  logic       Overflow;

  always #5 clk = ~clk;

  uart_tx_engine dut (
    .SysClk(clk), .Reset(Reset), .WrData(WrData), .WrEn(WrEn),
    .ParityMode(ParityMode), .SendBreak(SendBreak), .Tx(Tx), .Busy(Busy),
    .Empty(Empty), .Full(Full), .Count(Count), .Overflow(Overflow)
  );

  typedef struct {
    bit         is_break;
    logic [7:0] data;
    logic [1:0] mode;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_end = -100;
  int   last_brk_len = 0;
  int   ovf_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : ovf_counter
    forever begin
      @(posedge clk); #1;
      if (Overflow === 1'b1) ovf_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void pushFrame(input logic [7:0] d, input logic [1:0] m, input bit b2b);
    exp_t e;
    e.is_break = 1'b0;
    e.data = d;
    e.mode = m;
    e.b2b = b2b;
    exp_q.push_back(e);
  endfunction

  function automatic void pushBreak();
    exp_t e;
    e.is_break = 1'b1;
    e.data = '0;
    e.mode = '0;
    e.b2b = 1'b0;
    exp_q.push_back(e);
  endfunction

  // Reference line waveform: start, data LSB first, optional parity, stop bits.
  task automatic checkFrame(input exp_t e);
    logic bits[$];
    logic par;
    int   start;
    int   bad_at;
    start = cyc;
    bad_at = -1;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(e.data[i]);
    if (e.mode == 2'b01 || e.mode == 2'b10) begin
      par = ($countones(e.data) % 2) == 1;
      if (e.mode == 2'b10) par = !par;
      bits.push_back(par);
    end
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size() * DIV; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (Reset) begin
        exp_q.delete();
        return;
      end
      if (Tx !== bits[i / DIV] && bad_at < 0) bad_at = i;
    end
    checkOutput($sformatf("frame 0x%02h mode %0d first bad cycle", e.data, e.mode), bad_at, -1);
    if (e.b2b) checkOutput($sformatf("frame 0x%02h idle gap", e.data), start - last_end, 0);
    last_end = start + bits.size() * DIV;
  endtask

  // Break must end on the first edge at or after MINBRK where SendBreak is low.
  task automatic checkBreak();
    int exp_len;
    int meas_len;
    exp_len = -1;
    meas_len = -1;
    for (int j = 1; j <= MINBRK + 5000; j++) begin
      @(posedge clk); #1;
      if (Reset) begin
        exp_q.delete();
        return;
      end
      if (exp_len < 0 && j >= MINBRK && !SendBreak) exp_len = j;
      if (Tx === 1'b1) begin
        meas_len = j;
        break;
      end
    end
    last_brk_len = meas_len;
    checkOutput("break low cycles", meas_len, exp_len);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_tx;
    prev_tx = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (Reset) begin
        exp_q.delete();
        prev_tx = 1'b1;
      end else if (prev_tx === 1'b1 && Tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected Tx activity", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_break) checkBreak();
          else checkFrame(e);
        end
        prev_tx = 1'b1;
      end else begin
        prev_tx = Tx;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    WrData = d;
    ParityMode = m;
    WrEn = 1'b1;
  endtask

  task automatic releaseWrite();
    @(negedge clk);
    WrEn = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && Busy === 1'b0 && Empty === 1'b1) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle reached within budget", n < budget, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic timedFrame(input logic [7:0] d, input logic [1:0] m, input int exp_cycles,
                            input string tag);
    int n;
    pushFrame(d, m, 1'b0);
    applyStimulus(d, m);
    @(posedge clk); #1;
    checkOutput({tag, " Tx high at write edge"}, Tx, 1);
    releaseWrite();
    @(posedge clk); #1;
    checkOutput({tag, " Tx low one edge later"}, Tx, 0);
    n = 0;
    while (Busy === 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, " busy cycles"}, n, exp_cycles);
    waitIdle(5000);
  endtask

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int ovf_base;
    int nwords;
    int low_cnt;
    logic [1:0] m;
    logic [7:0] d;

    Reset = 1'b1;
    WrData = '0;
    WrEn = 1'b0;
    ParityMode = 2'b00;
    SendBreak = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset Tx", Tx, 1);
    checkOutput("reset Busy", Busy, 0);
    checkOutput("reset Empty", Empty, 1);
    checkOutput("reset Full", Full, 0);
    checkOutput("reset Count", Count, 0);
    checkOutput("reset Overflow", Overflow, 0);
    @(negedge clk);
    Reset = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] single frame, no parity");
    timedFrame(8'hA5, 2'b00, FRAME, "A5 none");

    $display("[TB] parity even/odd");
    timedFrame(8'h07, 2'b01, FRAME + DIV, "07 even");
    timedFrame(8'h07, 2'b10, FRAME + DIV, "07 odd");

    $display("[TB] parity change mid-frame");
    pushFrame(8'h3C, 2'b01, 1'b0);
    applyStimulus(8'h3C, 2'b01);
    releaseWrite();
    repeat (300) @(negedge clk);
    ParityMode = 2'b10;
    waitIdle(5000);
    ParityMode = 2'b00;

    $display("[TB] burst of 18 writes");
    ovf_base = ovf_cnt;
    for (int i = 0; i < 18; i++) begin
      if (i <= 16) pushFrame(8'(i), 2'b00, i > 0);
      applyStimulus(8'(i), 2'b00);
    end
    releaseWrite();
    @(posedge clk); #1;
    checkOutput("burst Full", Full, 1);
    checkOutput("burst Count", Count, 16);
    checkOutput("burst Empty", Empty, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("burst overflow pulses", ovf_cnt - ovf_base, 1);
    waitIdle(25000);

    $display("[TB] short and long break");
    pushBreak();
    @(negedge clk);
    SendBreak = 1'b1;
    repeat (10) @(negedge clk);
    SendBreak = 1'b0;
    waitIdle(5000);
    checkOutput("short break length", last_brk_len, MINBRK);
    pushBreak();
    @(negedge clk);
    SendBreak = 1'b1;
    repeat (2000) @(negedge clk);
    SendBreak = 1'b0;
    waitIdle(5000);
    checkOutput("long break length", last_brk_len, 2000);

    $display("[TB] break requested mid-frame");
    pushFrame(8'h5A, 2'b00, 1'b0);
    pushBreak();
    pushFrame(8'hC3, 2'b00, 1'b0);
    pushFrame(8'h81, 2'b00, 1'b1);
    applyStimulus(8'h5A, 2'b00);
    applyStimulus(8'hC3, 2'b00);
    applyStimulus(8'h81, 2'b00);
    releaseWrite();
    repeat (300) @(negedge clk);
    SendBreak = 1'b1;
    repeat (FRAME) @(negedge clk);
    SendBreak = 1'b0;
    waitIdle(10000);

    $display("[TB] randomized batches");
    for (int b = 0; b < 5; b++) begin
      m = 2'($urandom_range(0, 3));
      nwords = $urandom_range(1, 3);
      for (int i = 0; i < nwords; i++) begin
        d = 8'($urandom_range(0, 255));
        pushFrame(d, m, i > 0);
        applyStimulus(d, m);
      end
      releaseWrite();
      waitIdle(6000);
    end

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      pushFrame(d, 2'b00, i > 0);
      applyStimulus(d, 2'b00);
    end
    releaseWrite();
    repeat (495) @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort Tx", Tx, 1);
    checkOutput("abort Count", Count, 0);
    checkOutput("abort Empty", Empty, 1);
    checkOutput("abort Busy", Busy, 0);
    @(negedge clk);
    Reset = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (Tx !== 1'b1) low_cnt++;
    end
    checkOutput("Tx low cycles after abort", low_cnt, 0);
    checkOutput("total overflow pulses", ovf_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
